// File: rtl/commit_trace_fifo.sv
// Commit trace FIFO: captures a ROB retirement group of up to `size` entries in one cycle
// and replays the entries one per cycle, in program order, with first-word fall-through.
module commit_trace_fifo #(
    parameter int size  = 8,
    parameter int depth = 16,
    parameter int width = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [$clog2(size):0]     commit_cnt,
    input  logic [$clog2(size)-1:0]   front_tag,
    input  logic [width-1:0]          rob_pc   [size],
    input  logic [4:0]                rob_rd   [size],
    input  logic [width-1:0]          rob_data [size],
    input  logic                      rob_we   [size],
    output logic                      stall,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [width-1:0]          out_pc,
    output logic [width-1:0]          out_data,
    output logic [4:0]                out_rd,
    output logic                      out_we,
    output logic [31:0]               out_seq,
    output logic [$clog2(depth):0]    count,
    output logic                      overflow
);

    localparam int TW = $clog2(size);
    localparam int CW = $clog2(size) + 1;
    localparam int PW = $clog2(depth);
    localparam int NW = $clog2(depth) + 1;

    logic [width-1:0] pc_q   [depth];
    logic [width-1:0] data_q [depth];
    logic [4:0]       rd_q   [depth];
    logic             we_q   [depth];
    logic [31:0]      sq_q   [depth];

    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [NW-1:0] count_q, count_d;
    logic [31:0]   seq_q, seq_d;
    logic          ovf_q, ovf_d;

    logic [NW-1:0] space, cnt_ext;
    logic          accept, deq;
    logic [PW-1:0] wr_idx [size];
    logic [TW-1:0] src    [size];
    logic          wr_en  [size];

    always_comb begin
        space   = NW'(depth) - count_q;
        cnt_ext = NW'(commit_cnt);
        // Space is judged on the start-of-cycle count; a same-cycle dequeue does not help.
        accept  = (commit_cnt != '0) && (cnt_ext <= space);
        deq     = out_valid & out_ready;
        head_d  = head_q + PW'(deq);
        tail_d  = accept ? tail_q + PW'(commit_cnt) : tail_q;
        seq_d   = accept ? seq_q + 32'(commit_cnt) : seq_q;
        count_d = count_q + (accept ? cnt_ext : '0) - NW'(deq);
        ovf_d   = ovf_q | ((commit_cnt != '0) && !accept);
        for (int unsigned i = 0; i < size; i++) begin
            wr_idx[i] = tail_q + PW'(i);
            src[i]    = front_tag + TW'(i);
            wr_en[i]  = accept && (CW'(i) < commit_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            seq_q   <= '0;
            ovf_q   <= 1'b0;
            for (int unsigned j = 0; j < depth; j++) begin
                pc_q[j]   <= '0;
                data_q[j] <= '0;
                rd_q[j]   <= '0;
                we_q[j]   <= 1'b0;
                sq_q[j]   <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            seq_q   <= seq_d;
            ovf_q   <= ovf_d;
            for (int unsigned i = 0; i < size; i++) begin
                if (wr_en[i]) begin
                    pc_q[wr_idx[i]]   <= rob_pc[src[i]];
                    data_q[wr_idx[i]] <= rob_data[src[i]];
                    rd_q[wr_idx[i]]   <= rob_rd[src[i]];
                    we_q[wr_idx[i]]   <= rob_we[src[i]] & (rob_rd[src[i]] != 5'd0);
                    sq_q[wr_idx[i]]   <= seq_q + 32'(i);
                end
            end
        end
    end

    assign out_valid = (count_q != '0);
    assign stall     = (count_q > NW'(depth - size));
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign out_pc    = pc_q[head_q];
    assign out_data  = data_q[head_q];
    assign out_rd    = rd_q[head_q];
    assign out_we    = we_q[head_q];
    assign out_seq   = sq_q[head_q];

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Bench for commit_trace_fifo: directed scenarios plus random traffic, checked every
// cycle against a queue-based reference model of the trace buffer.
module tb_commit_trace_fifo;

    localparam int SIZE  = 8;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  commit_cnt;
    logic [2:0]  front_tag;
    logic [31:0] rob_pc   [SIZE];
    logic [4:0]  rob_rd   [SIZE];
    logic [31:0] rob_data [SIZE];
    logic        rob_we   [SIZE];
    logic        stall, out_valid, out_ready, out_we, overflow;
    logic [31:0] out_pc, out_data, out_seq;
    logic [4:0]  out_rd;
    logic [4:0]  count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        we;
        logic [31:0] seq;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_seq = '0;
    logic        m_ovf = 1'b0;

    commit_trace_fifo #(.size(SIZE), .depth(DEPTH), .width(32)) dut (
        .clk(clk), .rst(rst), .commit_cnt(commit_cnt), .front_tag(front_tag),
        .rob_pc(rob_pc), .rob_rd(rob_rd), .rob_data(rob_data), .rob_we(rob_we),
        .stall(stall), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_data(out_data), .out_rd(out_rd), .out_we(out_we),
        .out_seq(out_seq), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare();
        chk("valid", 64'(out_valid), 64'(mq.size() != 0));
        chk("count", 64'(count), 64'(mq.size()));
        chk("stall", 64'(stall), 64'(mq.size() > DEPTH - SIZE));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        if (mq.size() != 0) begin
            chk("head_pc", 64'(out_pc), 64'(mq[0].pc));
            chk("head_rd", 64'(out_rd), 64'(mq[0].rd));
            chk("head_data", 64'(out_data), 64'(mq[0].data));
            chk("head_we", 64'(out_we), 64'(mq[0].we));
            chk("head_seq", 64'(out_seq), 64'(mq[0].seq));
        end
    endtask

    // Advance one clock: decide the model's outcome from pre-edge inputs, then compare.
    task automatic cycle();
        int   n;
        bit   deq, acc;
        ent_t e;
        n   = int'(commit_cnt);
        deq = (mq.size() != 0) && out_ready;
        acc = (n > 0) && (n <= DEPTH - mq.size());
        @(posedge clk);
        #1;
        if (rst) begin
            mq.delete();
            m_seq = '0;
            m_ovf = 1'b0;
        end else begin
            if (deq) void'(mq.pop_front());
            if (acc) begin
                for (int i = 0; i < n; i++) begin
                    int s;
                    s      = (int'(front_tag) + i) % SIZE;
                    e.pc   = rob_pc[s];
                    e.rd   = rob_rd[s];
                    e.data = rob_data[s];
                    e.we   = rob_we[s] && (rob_rd[s] != 0);
                    e.seq  = m_seq + 32'(i);
                    mq.push_back(e);
                end
                m_seq = m_seq + 32'(n);
            end else if (n > 0) begin
                m_ovf = 1'b1;
            end
        end
        compare();
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        commit_cnt = '0;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic randomize_rob();
        for (int k = 0; k < SIZE; k++) begin
            rob_pc[k]   = $urandom;
            rob_rd[k]   = 5'($urandom_range(0, 31));
            rob_data[k] = $urandom;
            rob_we[k]   = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        rst        = 1'b1;
        commit_cnt = '0;
        front_tag  = '0;
        out_ready  = 1'b0;
        randomize_rob();

        // Reset then idle
        do_reset();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_seq", 64'(out_seq), 64'd0);
        chk("rst_pc", 64'(out_pc), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_rd", 64'(out_rd), 64'd0);
        chk("rst_we", 64'(out_we), 64'd0);
        cycle();

        // Single commit from slot 3
        rob_pc[3] = 32'h60; rob_rd[3] = 5'd5; rob_data[3] = 32'hDEAD; rob_we[3] = 1'b1;
        commit_cnt = 4'd1; front_tag = 3'd3; out_ready = 1'b1;
        cycle();
        commit_cnt = '0;
        chk("single_valid", 64'(out_valid), 64'd1);
        chk("single_pc", 64'(out_pc), 64'h60);
        chk("single_rd", 64'(out_rd), 64'd5);
        chk("single_data", 64'(out_data), 64'hDEAD);
        chk("single_we", 64'(out_we), 64'd1);
        chk("single_seq", 64'(out_seq), 64'd0);
        cycle();
        chk("single_drained", 64'(out_valid), 64'd0);

        // Wrapped burst starting at ROB slot 6
        do_reset();
        for (int k = 0; k < SIZE; k++) begin
            rob_pc[k] = 32'h100 + 32'(4 * k); rob_rd[k] = 5'(k + 1); rob_we[k] = 1'b1;
        end
        commit_cnt = 4'd8; front_tag = 3'd6; out_ready = 1'b1;
        cycle();
        commit_cnt = '0;
        for (int i = 0; i < 8; i++) begin
            chk("burst_pc", 64'(out_pc), 64'(32'h100 + 32'(4 * ((6 + i) % 8))));
            chk("burst_seq", 64'(out_seq), 64'(i));
            cycle();
        end
        chk("burst_drained", 64'(out_valid), 64'd0);

        // rd = 0 masks the write enable but keeps the data
        do_reset();
        rob_rd[0] = 5'd0; rob_we[0] = 1'b1; rob_data[0] = 32'h1234_5678;
        commit_cnt = 4'd1; front_tag = 3'd0; out_ready = 1'b0;
        cycle();
        commit_cnt = '0;
        chk("rd0_we", 64'(out_we), 64'd0);
        chk("rd0_data", 64'(out_data), 64'h1234_5678);

        // Backpressure until full, then overflow, then drain
        do_reset();
        randomize_rob();
        out_ready = 1'b0; front_tag = 3'd2;
        commit_cnt = 4'd8; cycle();
        chk("bp_stall8", 64'(stall), 64'd0);
        commit_cnt = 4'd8; cycle();
        chk("bp_count16", 64'(count), 64'd16);
        chk("bp_stall16", 64'(stall), 64'd1);
        commit_cnt = 4'd1; cycle();
        chk("bp_overflow", 64'(overflow), 64'd1);
        chk("bp_count_held", 64'(count), 64'd16);
        commit_cnt = '0; out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("bp_drain_seq", 64'(out_seq), 64'(i));
            cycle();
        end
        chk("bp_empty", 64'(out_valid), 64'd0);

        // Simultaneous enqueue/dequeue at the acceptance boundary, then mid-stream reset
        do_reset();
        out_ready = 1'b0;
        commit_cnt = 4'd8; cycle();
        commit_cnt = 4'd4; cycle();
        chk("sim_count12", 64'(count), 64'd12);
        out_ready = 1'b1; commit_cnt = 4'd4; cycle();
        chk("sim_accept15", 64'(count), 64'd15);
        chk("sim_no_ovf", 64'(overflow), 64'd0);
        commit_cnt = '0; cycle(); cycle();
        chk("sim_count13", 64'(count), 64'd13);
        commit_cnt = 4'd4; cycle();
        chk("sim_reject12", 64'(count), 64'd12);
        chk("sim_ovf", 64'(overflow), 64'd1);
        rst = 1'b1; commit_cnt = '0; cycle(); rst = 1'b0;
        chk("sim_rst_count", 64'(count), 64'd0);
        chk("sim_rst_ovf", 64'(overflow), 64'd0);
        out_ready = 1'b0; commit_cnt = 4'd1; cycle();
        commit_cnt = '0;
        chk("sim_seq_restart", 64'(out_seq), 64'd0);

        // Random traffic, including groups that wrap both ROB slot and FIFO position
        for (int c = 0; c < 400; c++) begin
            randomize_rob();
            rst        = ($urandom_range(0, 99) == 0);
            commit_cnt = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 8));
            front_tag  = 3'($urandom_range(0, 7));
            out_ready  = ($urandom_range(0, 3) != 0);
            cycle();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/commit_trace_fifo.md
# commit_trace_fifo

Buffers instructions retired by the ROB and replays them one per cycle, in program order, to the commit checker and register-state compare logic. The ROB may retire up to `size` entries in one cycle, starting at its front tag; this block captures the whole group in one cycle and serializes it through a circular FIFO behind a valid/ready handshake. It sits between the ROB dequeue port and the verification checker.

## Interface
- `size`, 8: ROB entries (power of 2); maximum commits per cycle.
- `depth`, 16: FIFO entries (power of 2, ≥ `size`).
- `width`, 32: data and PC width.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `commit_cnt`  in  $clog2(size)+1  entries retired this cycle (0..size).
- `front_tag`  in  $clog2(size)  ROB slot of the oldest retiring entry.
- `rob_pc[size]`  in  width  PC per ROB slot.
- `rob_rd[size]`  in  5  destination register per slot.
- `rob_data[size]`  in  width  result per slot.
- `rob_we[size]`  in  1  slot writes a register.
- `stall`  out  1  `count > depth - size`; ROB must not retire while high.
- `out_valid`  out  1  head entry present.
- `out_ready`  in  1  consumer accepts the head this cycle.
- `out_pc`, `out_data`  out  width  head entry fields.
- `out_rd`  out  5  head destination.
- `out_we`  out  1  head register write; always 0 when `out_rd` = 0.
- `out_seq`  out  32  retirement sequence number of the head.
- `count`  out  $clog2(depth)+1  occupied entries.
- `overflow`  out  1  sticky; a commit group was dropped.

## Operation
- Storage: `depth` entries of {pc, rd, data, we, seq}; `head` and `tail` pointers of $clog2(depth) bits that wrap modulo `depth`; `count` register; 32-bit `seq_next` counter.
- Enqueue: slot i of the group is ROB slot `(front_tag + i) % size`, for i = 0..commit_cnt-1. It is written to `(tail + i) % depth` with seq = `seq_next + i`. Then `tail += commit_cnt` and `seq_next += commit_cnt`.
- `we` is stored as `rob_we & (rob_rd != 0)`.
- Acceptance: the group is taken only if `commit_cnt <= depth - count`, where `count` is the value at the start of the cycle. A same-cycle dequeue does not free space for the group.
- Rejected group (any `commit_cnt > 0` that fails the check): nothing is written, the pointers and `seq_next` do not move, and `overflow` sets and stays high until `rst`.
- Dequeue: `out_valid & out_ready` increments `head`. `out_ready` is ignored while `out_valid = 0`.
- Count update: `count` next = `count + accepted_cnt - deq`, where `deq` is 0 or 1.
- Output: first-word fall-through. All `out_*` fields come combinationally from `storage[head]`; `out_valid = (count != 0)`. With `out_valid` = 0, the fields are don't-care but must not be X after reset.
- `stall` is combinational from `count` only.

## Timing
- Reset (rst high at an edge): head = tail = 0, count = 0, seq_next = 0, overflow = 0. Afterwards `out_valid` = 0, `stall` = 0, and all `out_*` fields are 0.
- A reset mid-stream discards all entries; `seq_next` restarts at 0.
- Latency: a group accepted at edge N appears at the head (if the FIFO was empty) in the cycle after edge N. There is no same-cycle bypass from the ROB inputs to `out_*`.
- Throughput: 1 dequeue per cycle, up to `size` enqueues per cycle.
- Simultaneous enqueue and dequeue in one cycle: both happen; pointers update independently.
- Full FIFO (count = depth): `out_valid` = 1, `stall` = 1, and any nonzero `commit_cnt` overflows.
- Empty FIFO with `commit_cnt` = 0: no state change.
- Both `front_tag + i` and `tail + i` wrap correctly, including a group that wraps both at once.

## Test plan
- Reset then idle: after `rst` held 2 cycles with `commit_cnt` = 0 → `out_valid` = 0, `count` = 0, `stall` = 0, `overflow` = 0, `out_seq` = 0.
- Single commit: `commit_cnt` = 1, `front_tag` = 3, slot 3 = {pc 0x60, rd 5, data 0xDEAD, we 1}, `out_ready` = 1 → the next cycle shows `out_valid` = 1 with pc 0x60, rd 5, data 0xDEAD, we 1, seq 0; the cycle after, `out_valid` = 0.
- Wrapped burst: `commit_cnt` = 8, `front_tag` = 6, slot k carries pc 0x100 + 4k, `out_ready` = 1 → eight consecutive outputs with pcs 0x118, 0x11C, 0x100, …, 0x114 and seqs 0..7.
- rd = 0 masking: a commit with rd 0 and we 1 → `out_we` = 0 and the data is passed through unchanged.
- Backpressure and full: `out_ready` = 0, commits of 8 then 8 → `count` = 16 and `stall` = 1 (already 1 once count = 9). A further `commit_cnt` = 1 → `overflow` = 1 and `count` stays 16. Releasing `out_ready` drains seqs 0..15 in order.
- Simultaneous events and reset: with `count` = 12, `commit_cnt` = 4 and a dequeue in the same cycle → accepted, `count` = 15. With `count` = 13, `commit_cnt` = 4 and a dequeue → rejected, `count` = 12, `overflow` set. Asserting `rst` mid-stream → `count` = 0 and `overflow` = 0 on the next cycle, and the next commit carries seq 0.
